serv_mem_arbiter: RTL and testbench

Merges the split instruction-memory and data-memory ports of serv_top onto one shared memory port. Each port has a command/address channel (ca), a write-data/mask channel (dm) and a read-data channel (rd). The block arbitrates the ca channel round-robin and records the source of every accepted read in an in-order route FIFO. It uses that FIFO to steer read responses back to the requester that issued them. It sits between serv_top and a single-ported memory or bus bridge.

---
 rtl/serv_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_serv_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_mem_arbiter.sv
// Shared-port memory arbiter for serv_top: round-robin command arbitration between the
// instruction and data ports, with an in-order route FIFO steering read data back.
module serv_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic [31:0]      i_i_ca_adr,
    input  logic             i_i_ca_vld,
    output logic             o_i_ca_rdy,
    output logic [31:0]      o_i_rd_dat,
    output logic             o_i_rd_vld,
    input  logic             i_i_rd_rdy,

    input  logic             i_d_ca_cmd,
    input  logic [31:0]      i_d_ca_adr,
    input  logic             i_d_ca_vld,
    output logic             o_d_ca_rdy,
    input  logic [31:0]      i_d_dm_dat,
    input  logic [3:0]       i_d_dm_msk,
    input  logic             i_d_dm_vld,
    output logic             o_d_dm_rdy,
    output logic [31:0]      o_d_rd_dat,
    output logic             o_d_rd_vld,
    input  logic             i_d_rd_rdy,

    output logic             o_m_ca_cmd,
    output logic [31:0]      o_m_ca_adr,
    output logic             o_m_ca_vld,
    input  logic             i_m_ca_rdy,
    output logic [31:0]      o_m_dm_dat,
    output logic [3:0]       o_m_dm_msk,
    output logic             o_m_dm_vld,
    input  logic             i_m_dm_rdy,
    input  logic [31:0]      i_m_rd_dat,
    input  logic             i_m_rd_vld,
    output logic             o_m_rd_rdy,

    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_I = 2'd1;
    localparam logic [1:0] ST_LOCK_D = 2'd2;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    logic [1:0]                 state_q, state_d;
    logic                       last_winner_q, last_winner_d;
    logic [MAX_OUTSTANDING-1:0] route_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       err_q, err_d;

    logic sel_d;
    logic sel_vld;
    logic sel_cmd;
    logic fifo_full;
    logic fifo_empty;
    logic block;
    logic accept;
    logic push;
    logic pop;
    logic head_src;

    // A locked port keeps the grant so the memory side sees stable vld/adr until accepted.
    always_comb begin
        sel_d = SRC_I;
        case (state_q)
            ST_LOCK_I: sel_d = SRC_I;
            ST_LOCK_D: sel_d = SRC_D;
            default: begin
                if (i_i_ca_vld && i_d_ca_vld) sel_d = ~last_winner_q;
                else                          sel_d = i_d_ca_vld;
            end
        endcase
    end

    assign sel_vld    = sel_d ? i_d_ca_vld : i_i_ca_vld;
    assign sel_cmd    = sel_d & i_d_ca_cmd;
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign block      = !sel_cmd && fifo_full;

    assign o_m_ca_vld = sel_vld && !block;
    assign o_m_ca_cmd = sel_cmd;
    assign o_m_ca_adr = sel_d ? i_d_ca_adr : i_i_ca_adr;
    assign o_i_ca_rdy = (sel_d == SRC_I) && i_m_ca_rdy && !block;
    assign o_d_ca_rdy = (sel_d == SRC_D) && i_m_ca_rdy && !block;

    assign accept = o_m_ca_vld && i_m_ca_rdy;
    assign push   = accept && !sel_cmd;

    assign head_src   = route_q[rd_ptr_q];
    assign o_m_rd_rdy = !fifo_empty && (head_src ? i_d_rd_rdy : i_i_rd_rdy);
    assign o_i_rd_vld = !fifo_empty && (head_src == SRC_I) && i_m_rd_vld;
    assign o_d_rd_vld = !fifo_empty && (head_src == SRC_D) && i_m_rd_vld;
    assign o_i_rd_dat = i_m_rd_dat;
    assign o_d_rd_dat = i_m_rd_dat;
    assign pop        = i_m_rd_vld && o_m_rd_rdy;

    assign o_m_dm_dat = i_d_dm_dat;
    assign o_m_dm_msk = i_d_dm_msk;
    assign o_m_dm_vld = i_d_dm_vld;
    assign o_d_dm_rdy = i_m_dm_rdy;

    assign o_outstanding = count_q;
    assign o_err         = err_q;

    always_comb begin
        state_d       = state_q;
        last_winner_d = accept ? sel_d : last_winner_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d         = err_q || (fifo_empty && i_m_rd_vld);
        case (state_q)
            ST_IDLE: begin
                if (sel_vld && !accept) state_d = sel_d ? ST_LOCK_D : ST_LOCK_I;
            end
            ST_LOCK_I, ST_LOCK_D: begin
                if (accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_winner_q <= SRC_D;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            count_q       <= count_d;
            err_q         <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: route slots hold no reset; an entry is only read once the count says it was written.
    always_ff @(posedge clock) begin
        if (push) route_q[wr_ptr_q] <= sel_d;
    end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Randomized scoreboard bench for serv_mem_arbiter: stimulus pushes expected commands,
// a negedge monitor predicts grants, blocking and read routing from the arbitration rules.
module tb_serv_mem_arbiter;

    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    typedef struct {
        logic        cmd;
        logic [31:0] adr;
    } cmd_t;

    typedef struct {
        logic        src;
        logic [31:0] data;
    } route_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   i_i_ca_adr;
    logic          i_i_ca_vld;
    logic          o_i_ca_rdy;
    logic [31:0]   o_i_rd_dat;
    logic          o_i_rd_vld;
    logic          i_i_rd_rdy;
    logic          i_d_ca_cmd;
    logic [31:0]   i_d_ca_adr;
    logic          i_d_ca_vld;
    logic          o_d_ca_rdy;
    logic [31:0]   i_d_dm_dat;
    logic [3:0]    i_d_dm_msk;
    logic          i_d_dm_vld;
    logic          o_d_dm_rdy;
    logic [31:0]   o_d_rd_dat;
    logic          o_d_rd_vld;
    logic          i_d_rd_rdy;
    logic          o_m_ca_cmd;
    logic [31:0]   o_m_ca_adr;
    logic          o_m_ca_vld;
    logic          i_m_ca_rdy;
    logic [31:0]   o_m_dm_dat;
    logic [3:0]    o_m_dm_msk;
    logic          o_m_dm_vld;
    logic          i_m_dm_rdy;
    logic [31:0]   i_m_rd_dat;
    logic          i_m_rd_vld;
    logic          o_m_rd_rdy;
    logic [CW-1:0] o_outstanding;
    logic          o_err;

    serv_mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_i_ca_adr   (i_i_ca_adr),
        .i_i_ca_vld   (i_i_ca_vld),
        .o_i_ca_rdy   (o_i_ca_rdy),
        .o_i_rd_dat   (o_i_rd_dat),
        .o_i_rd_vld   (o_i_rd_vld),
        .i_i_rd_rdy   (i_i_rd_rdy),
        .i_d_ca_cmd   (i_d_ca_cmd),
        .i_d_ca_adr   (i_d_ca_adr),
        .i_d_ca_vld   (i_d_ca_vld),
        .o_d_ca_rdy   (o_d_ca_rdy),
        .i_d_dm_dat   (i_d_dm_dat),
        .i_d_dm_msk   (i_d_dm_msk),
        .i_d_dm_vld   (i_d_dm_vld),
        .o_d_dm_rdy   (o_d_dm_rdy),
        .o_d_rd_dat   (o_d_rd_dat),
        .o_d_rd_vld   (o_d_rd_vld),
        .i_d_rd_rdy   (i_d_rd_rdy),
        .o_m_ca_cmd   (o_m_ca_cmd),
        .o_m_ca_adr   (o_m_ca_adr),
        .o_m_ca_vld   (o_m_ca_vld),
        .i_m_ca_rdy   (i_m_ca_rdy),
        .o_m_dm_dat   (o_m_dm_dat),
        .o_m_dm_msk   (o_m_dm_msk),
        .o_m_dm_vld   (o_m_dm_vld),
        .i_m_dm_rdy   (i_m_dm_rdy),
        .i_m_rd_dat   (i_m_rd_dat),
        .i_m_rd_vld   (i_m_rd_vld),
        .o_m_rd_rdy   (o_m_rd_rdy),
        .o_outstanding(o_outstanding),
        .o_err        (o_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs (percent probabilities) and control set by the main sequence.
    int p_req  = 0;
    int p_mrdy = 100;
    int p_rsp  = 100;
    int p_rd   = 100;
    int run        = 0;
    int hold_rsp   = 0;
    int inject_rsp = 0;
    int rst_cycles = 2;

    // Scoreboard state: per-port pending commands and in-order expected read returns.
    cmd_t        exp_i_q[$];
    cmd_t        exp_d_q[$];
    route_t      rd_q[$];
    logic [31:0] rsp_q[$];
    int          held   = -1;
    int          last   = 1;
    logic        err_m  = 1'b0;
    int          saw_tie   = 0;
    int          saw_lock  = 0;
    int          saw_block = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEADBEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver and memory responder: one process so reset, requests and responses never race.
    initial begin : stim
        logic        was_rst, i_acc, d_acc, m_rd_acc, rsp_done, rsp_active;
        logic [31:0] m_adr;
        cmd_t        c;
        rsp_active = 1'b0;
        reset = 1'b1;
        i_i_ca_adr = '0; i_i_ca_vld = 1'b0; i_i_rd_rdy = 1'b0;
        i_d_ca_cmd = 1'b0; i_d_ca_adr = '0; i_d_ca_vld = 1'b0; i_d_rd_rdy = 1'b0;
        i_d_dm_dat = '0; i_d_dm_msk = '0; i_d_dm_vld = 1'b0;
        i_m_ca_rdy = 1'b0; i_m_dm_rdy = 1'b0; i_m_rd_dat = '0; i_m_rd_vld = 1'b0;
        forever begin
            @(negedge clock);
            was_rst  = reset;
            i_acc    = !was_rst && i_i_ca_vld && o_i_ca_rdy;
            d_acc    = !was_rst && i_d_ca_vld && o_d_ca_rdy;
            m_rd_acc = !was_rst && o_m_ca_vld && i_m_ca_rdy && !o_m_ca_cmd;
            m_adr    = o_m_ca_adr;
            rsp_done = !was_rst && i_m_rd_vld && o_m_rd_rdy;
            @(posedge clock);
            #1;
            if (rst_cycles > 0) begin
                rst_cycles--;
                reset = 1'b1;
                i_i_ca_vld = 1'b0;
                i_d_ca_vld = 1'b0;
                i_m_rd_vld = 1'b0;
                rsp_active = 1'b0;
                rsp_q.delete();
            end else begin
                reset = 1'b0;
                if (m_rd_acc) rsp_q.push_back(mem_data(m_adr));
                if (i_acc) i_i_ca_vld = 1'b0;
                if (d_acc) i_d_ca_vld = 1'b0;
                if (run != 0 && !i_i_ca_vld && $urandom_range(99) < p_req) begin
                    c.cmd = 1'b0;
                    c.adr = $urandom;
                    i_i_ca_adr = c.adr;
                    i_i_ca_vld = 1'b1;
                    exp_i_q.push_back(c);
                end
                if (run != 0 && !i_d_ca_vld && $urandom_range(99) < p_req) begin
                    c.cmd = 1'($urandom_range(1));
                    c.adr = $urandom;
                    i_d_ca_cmd = c.cmd;
                    i_d_ca_adr = c.adr;
                    i_d_ca_vld = 1'b1;
                    exp_d_q.push_back(c);
                end
                i_m_ca_rdy = ($urandom_range(99) < p_mrdy);
                i_i_rd_rdy = ($urandom_range(99) < p_rd);
                i_d_rd_rdy = ($urandom_range(99) < p_rd);
                i_m_dm_rdy = 1'($urandom_range(1));
                i_d_dm_vld = 1'($urandom_range(1));
                i_d_dm_dat = $urandom;
                i_d_dm_msk = 4'($urandom);
                if (rsp_active && rsp_done) begin
                    void'(rsp_q.pop_front());
                    rsp_active = 1'b0;
                end
                if (!rsp_active) begin
                    i_m_rd_vld = 1'b0;
                    if (inject_rsp > 0) begin
                        inject_rsp--;
                        i_m_rd_vld = 1'b1;
                        i_m_rd_dat = 32'h0BAD_0BAD;
                    end else if (hold_rsp == 0 && rsp_q.size() > 0 && $urandom_range(99) < p_rsp) begin
                        i_m_rd_vld = 1'b1;
                        i_m_rd_dat = rsp_q[0];
                        rsp_active = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: predicts every output from the arbitration and routing rules, one cycle at a time.
    initial begin : monitor
        int     n0, win;
        logic   is_rd, blocked, exp_vld, accept, owner, exp_mrdy;
        cmd_t   c;
        route_t r;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_i_q.delete();
                exp_d_q.delete();
                rd_q.delete();
                held  = -1;
                last  = 1;
                err_m = 1'b0;
            end else begin
                n0 = rd_q.size();
                check("outstanding", 32'(o_outstanding), 32'(n0));
                check("err", 32'(o_err), 32'(err_m));

                if (n0 > 0) begin
                    owner    = rd_q[0].src;
                    exp_mrdy = owner ? i_d_rd_rdy : i_i_rd_rdy;
                    check("m_rd_rdy", 32'(o_m_rd_rdy), 32'(exp_mrdy));
                    check("i_rd_vld", 32'(o_i_rd_vld), 32'(!owner && i_m_rd_vld));
                    check("d_rd_vld", 32'(o_d_rd_vld), 32'(owner && i_m_rd_vld));
                    if (i_m_rd_vld && exp_mrdy) begin
                        if (owner) check("d_rd_dat", o_d_rd_dat, rd_q[0].data);
                        else       check("i_rd_dat", o_i_rd_dat, rd_q[0].data);
                        void'(rd_q.pop_front());
                    end
                end else begin
                    check("m_rd_rdy_empty", 32'(o_m_rd_rdy), 32'd0);
                    check("rd_vld_empty", 32'({o_i_rd_vld, o_d_rd_vld}), 32'd0);
                    if (i_m_rd_vld) err_m = 1'b1;
                end

                win = -1;
                if (held >= 0) begin
                    win = held;
                    if ((held == 0 && exp_d_q.size() > 0) || (held == 1 && exp_i_q.size() > 0))
                        saw_lock++;
                end else if (exp_i_q.size() > 0 && exp_d_q.size() > 0) begin
                    win = (last == 1) ? 0 : 1;
                    saw_tie++;
                end else if (exp_d_q.size() > 0) win = 1;
                else if (exp_i_q.size() > 0)    win = 0;

                exp_vld = 1'b0;
                is_rd   = 1'b0;
                blocked = 1'b0;
                if (win >= 0) begin
                    c       = (win == 0) ? exp_i_q[0] : exp_d_q[0];
                    is_rd   = !c.cmd;
                    blocked = is_rd && (n0 == MAX);
                    exp_vld = !blocked;
                    if (blocked) saw_block++;
                end
                check("m_ca_vld", 32'(o_m_ca_vld), 32'(exp_vld));
                if (exp_vld) begin
                    check("m_ca_adr", o_m_ca_adr, c.adr);
                    check("m_ca_cmd", 32'(o_m_ca_cmd), 32'(c.cmd));
                end
                if (exp_i_q.size() > 0)
                    check("i_ca_rdy", 32'(o_i_ca_rdy), 32'(win == 0 && exp_vld && i_m_ca_rdy));
                if (exp_d_q.size() > 0)
                    check("d_ca_rdy", 32'(o_d_ca_rdy), 32'(win == 1 && exp_vld && i_m_ca_rdy));

                accept = exp_vld && i_m_ca_rdy;
                if (accept) begin
                    if (win == 0) void'(exp_i_q.pop_front());
                    else          void'(exp_d_q.pop_front());
                    if (is_rd) begin
                        r.src  = (win == 1);
                        r.data = mem_data(c.adr);
                        rd_q.push_back(r);
                    end
                    last = win;
                    held = -1;
                end else begin
                    held = win;
                end

                check("m_dm_dat", o_m_dm_dat, i_d_dm_dat);
                check("m_dm_ctl", 32'({o_m_dm_msk, o_m_dm_vld, o_d_dm_rdy}),
                      32'({i_d_dm_msk, i_d_dm_vld, i_m_dm_rdy}));
            end
        end
    end

    task automatic do_reset();
        rst_cycles = 2;
        repeat (4) @(negedge clock);
    endtask

    task automatic run_phase(input int req, input int mrdy, input int rsp, input int rd, input int cycles);
        p_req  = req;
        p_mrdy = mrdy;
        p_rsp  = rsp;
        p_rd   = rd;
        run    = 1;
        repeat (cycles) @(posedge clock);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin : main
        int k;
        repeat (4) @(negedge clock);
        check("rst_m_ca_vld", 32'(o_m_ca_vld), 32'd0);
        check("rst_m_rd_rdy", 32'(o_m_rd_rdy), 32'd0);
        check("rst_rd_vld", 32'({o_i_rd_vld, o_d_rd_vld}), 32'd0);
        check("rst_outstanding", 32'(o_outstanding), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);

        run_phase(70, 90, 15, 80, 1500);   // slow returns: FIFO fills, reads block
        run_phase(60, 30, 60, 60, 1500);   // slow command ready: locks held across cycles
        run_phase(50, 50, 50, 50, 1500);

        run    = 0;
        p_mrdy = 100;
        p_rsp  = 100;
        p_rd   = 100;
        k = 0;
        while ((exp_i_q.size() > 0 || exp_d_q.size() > 0 || rd_q.size() > 0) && k < 3000) begin
            @(posedge clock);
            k++;
        end
        repeat (3) @(negedge clock);
        check("drain_in_time", 32'(k < 3000), 32'd1);
        check("drain_outstanding", 32'(o_outstanding), 32'd0);

        check("cov_tie_seen", 32'(saw_tie > 0), 32'd1);
        check("cov_lock_seen", 32'(saw_lock > 0), 32'd1);
        check("cov_block_seen", 32'(saw_block > 0), 32'd1);

        inject_rsp = 1;
        repeat (3) @(negedge clock);
        check("err_set", 32'(o_err), 32'd1);
        repeat (5) @(negedge clock);
        check("err_sticky", 32'(o_err), 32'd1);
        do_reset();
        check("err_cleared", 32'(o_err), 32'd0);

        hold_rsp = 1;
        run_phase(80, 100, 0, 100, 40);
        run = 0;
        @(negedge clock);
        check("prefill_full", 32'(o_outstanding), 32'(MAX));
        do_reset();
        hold_rsp = 0;
        check("midrst_outstanding", 32'(o_outstanding), 32'd0);
        check("midrst_m_ca_vld", 32'(o_m_ca_vld), 32'd0);
        check("midrst_err", 32'(o_err), 32'd0);
        inject_rsp = 1;
        repeat (3) @(negedge clock);
        check("late_rsp_err", 32'(o_err), 32'd1);
        do_reset();
        check("final_err", 32'(o_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
